// File: rtl/key_event_scanner.sv
// Debounce/synchronise panel inputs, turn level changes into press/release events and
// queue them in a first-word-fall-through FIFO. Optional auto-repeat: KEYPAD_AUTOREPEAT_EN.
module key_event_scanner #(
    parameter int unsigned NCH       = 11,
    parameter int unsigned NDEB      = 5,
    parameter int unsigned NDELAY    = 650000,
    parameter int unsigned NBITS     = 20,
    parameter int unsigned CODE_W    = 4,
    parameter int unsigned AW        = 3,
    parameter int unsigned REP_DELAY = 25000000,
    parameter int unsigned REP_RATE  = 5000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    in_n,
    input  logic              rd_en,
    input  logic              clr_ovf,
    output logic              ev_valid,
    output logic [CODE_W-1:0] ev_code,
    output logic              ev_press,
    output logic              ev_rep,
    output logic [NCH-1:0]    level,
    output logic              ovf,
    output logic              led,
    output logic              irq_pin
);

    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned CW    = AW + 1;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned EW    = CODE_W + 2;
`else
    localparam int unsigned EW    = CODE_W + 1;
`endif

    logic [NCH-1:0]    r_sync1;
    logic [NCH-1:0]    r_sync2;
    logic [NDEB-1:0]   r_cand;
    logic [NBITS-1:0]  r_cnt [NDEB];
    logic [NCH-1:0]    r_level;
    logic [NCH-1:0]    r_level_d;
    logic [NCH-1:0]    r_pend;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_ovf;

    logic              w_any_pend;
    logic [CODE_W-1:0] w_push_idx;
    logic              w_push_lvl;
    logic              w_push_deb;
    logic [NCH-1:0]    w_clr_mask;
    logic              w_full;
    logic              w_pop;
    logic              w_push_req;
    logic              w_push_ok;
    logic              w_drop_ovf;
    logic [EW-1:0]     w_push_data;
    logic [EW-1:0]     w_head;

    // Input synchroniser and per-channel debounce; candidates preload the raw level in reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_level <= '0;
            r_cand  <= ~in_n[NDEB-1:0];
            for (int unsigned i = 0; i < NDEB; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_sync1 <= ~in_n;
            r_sync2 <= r_sync1;
            for (int unsigned i = 0; i < NDEB; i++) begin
                if (r_sync2[i] != r_cand[i]) begin
                    r_cand[i] <= r_sync2[i];
                    r_cnt[i]  <= '0;
                end else if (r_cnt[i] == NBITS'(NDELAY)) begin
                    r_level[i] <= r_cand[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + NBITS'(1);
                end
            end
            for (int unsigned i = NDEB; i < NCH; i++) begin
                r_level[i] <= r_sync2[i];
            end
        end
    end

    always_comb begin
        w_any_pend = 1'b0;
        w_push_idx = '0;
        w_push_lvl = 1'b0;
        w_push_deb = 1'b0;
        w_clr_mask = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (!w_any_pend && r_pend[i]) begin
                w_any_pend    = 1'b1;
                w_push_idx    = CODE_W'(i);
                w_push_lvl    = r_level[i];
                w_push_deb    = (i < NDEB);
                w_clr_mask[i] = 1'b1;
            end
        end
    end

    // The pushed bit is cleared even if a change lands the same cycle: the push already
    // carries the current level, so the two changes coalesce into one event.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_level_d <= '0;
            r_pend    <= '0;
        end else begin
            r_level_d <= r_level;
            r_pend    <= (r_pend | (r_level ^ r_level_d)) & ~w_clr_mask;
        end
    end

    assign w_full   = (r_count == CW'(DEPTH));
    assign ev_valid = (r_count != '0);
    assign w_pop    = rd_en & ev_valid;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned RMAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
    localparam int unsigned RW   = $clog2(RMAX + 1);

    logic              r_rep_active;
    logic [CODE_W-1:0] r_last_key;
    logic [RW-1:0]     r_rep_cnt;
    logic              r_rep_pend;
    logic              w_rep_req;
    logic              w_deb_press;

    assign w_rep_req   = r_rep_pend & ~w_any_pend;
    assign w_deb_press = w_any_pend & w_push_lvl & w_push_deb;
    assign w_push_req  = w_any_pend | w_rep_req;
    assign w_push_data = w_any_pend ? {w_push_idx, w_push_lvl, 1'b0} : {r_last_key, 1'b1, 1'b1};

    // Timer loads one short so the repeat is pushed exactly REP_DELAY / REP_RATE
    // cycles apart, allowing for the cycle spent in rep_pend.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rep_active <= 1'b0;
            r_last_key   <= '0;
            r_rep_cnt    <= '0;
            r_rep_pend   <= 1'b0;
        end else if (w_deb_press) begin
            r_rep_active <= 1'b1;
            r_last_key   <= w_push_idx;
            r_rep_cnt    <= RW'(REP_DELAY - 2);
            r_rep_pend   <= 1'b0;
        end else if (r_rep_active && !r_level[r_last_key]) begin
            r_rep_active <= 1'b0;
            r_rep_pend   <= 1'b0;
        end else begin
            if (w_rep_req) begin
                r_rep_pend <= 1'b0;
            end
            if (r_rep_active) begin
                if (r_rep_cnt == '0) begin
                    r_rep_pend <= 1'b1;
                    r_rep_cnt  <= RW'(REP_RATE - 1);
                end else begin
                    r_rep_cnt <= r_rep_cnt - RW'(1);
                end
            end
        end
    end

    assign ev_code  = ev_valid ? w_head[EW-1:2] : '0;
    assign ev_press = ev_valid & w_head[1];
    assign ev_rep   = ev_valid & w_head[0];
`else
    assign w_push_req  = w_any_pend;
    assign w_push_data = {w_push_idx, w_push_lvl};

    assign ev_code  = ev_valid ? w_head[EW-1:1] : '0;
    assign ev_press = ev_valid & w_head[0];
    assign ev_rep   = 1'b0;
`endif

    // A push into a full FIFO still succeeds when the head is popped the same cycle.
    assign w_push_ok  = w_push_req & (~w_full | w_pop);
    assign w_drop_ovf = w_any_pend & w_full & ~w_pop;
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push_ok && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop_ovf) begin
            r_ovf <= 1'b1;
        end else if (clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign level   = r_level;
    assign ovf     = r_ovf;
    assign led     = |r_level;
    assign irq_pin = ev_valid;

endmodule
